// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared constants for the console line receiver: uart register
//               addresses, status bit positions, control characters and the
//               receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    // uart register map
    localparam logic [1:0] UART_ADR_DATA = 2'b00;
    localparam logic [1:0] UART_ADR_STAT = 2'b10;

    // uart status bits
    localparam int ST_RX_RDY  = 0;
    localparam int ST_TX_BUSY = 1;

    // control characters
    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;
    localparam logic [7:0] CH_BS = 8'h08;

    // receiver state encoding
    typedef logic [3:0] state_t;
    localparam state_t GAP     = 4'd0;
    localparam state_t ST_RD   = 4'd1;
    localparam state_t ST_CHK  = 4'd2;
    localparam state_t DAT_RD  = 4'd3;
    localparam state_t DAT_CHK = 4'd4;
    localparam state_t EC_RD   = 4'd5;
    localparam state_t EC_CHK  = 4'd6;
    localparam state_t EC_WR   = 4'd7;
    localparam state_t DRAIN   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_buf
// Description : LINE_MAX x 8 line storage. One write port, one registered
//               read port whose output holds until the next read enable.
// Ports       : clk, rst       - clock / sync active-high reset (read reg only)
//               i_we, i_wr_idx, i_wr_data - write port
//               i_rd_en, i_rd_idx         - read request
//               o_rd_data                 - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf
    import console_pkg::*;
#(
    parameter int LINE_MAX = 32
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_we,
    input  wire logic [$clog2(LINE_MAX)-1:0] i_wr_idx,
    input  wire logic [7:0]                  i_wr_data,
    input  wire logic                        i_rd_en,
    input  wire logic [$clog2(LINE_MAX)-1:0] i_rd_idx,
    output logic      [7:0]                  o_rd_data
);

    logic [7:0] r_mem [LINE_MAX];

    // storage needs no reset: the line count gates what is ever read back
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_data <= 8'h00;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/console_line_rx.sv
`default_nettype none
// ============================================================================
// Module      : console_line_rx
// Description : Console line receiver. Polls the uart, reads and echoes
//               characters, edits them into a line buffer (backspace, LF
//               ignored, overflow flagged) and streams the finished line on a
//               valid/ready byte interface when CR arrives.
// Ports       : clk, rst                       - clock, sync active-high reset
//               uart_wr/rd/adr/din, uart_dout  - uart register master
//               out_data/valid/ready/last      - line byte stream
//               line_len, line_ovf             - attributes of drained line
// Revision    : 1.0 - initial release
// ============================================================================
module console_line_rx
    import console_pkg::*;
#(
    parameter int LINE_MAX = 32,
    parameter int POLL_GAP = 10,
    parameter int ECHO     = 1
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    output logic                           uart_wr,
    output logic                           uart_rd,
    output logic [1:0]                     uart_adr,
    output logic [7:0]                     uart_din,
    input  wire logic [7:0]                uart_dout,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  wire logic                      out_ready,
    output logic                           out_last,
    output logic [$clog2(LINE_MAX):0]      line_len,
    output logic                           line_ovf
);

    localparam int AW = $clog2(LINE_MAX);
    localparam int CW = AW + 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [CW-1:0] c_line_max = CW'(LINE_MAX);
    localparam logic [GW-1:0] c_gap_last = GW'(POLL_GAP - 1);
    localparam logic          c_echo_on  = (ECHO != 0);

    state_t          r_state;
    logic [GW-1:0]   r_gap;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [7:0]      r_echo;
    logic            r_close;     // pending CR closed a non-empty line
    logic [CW-1:0]   r_ptr;       // index of the byte currently presented

    state_t          w_next;
    logic            w_we;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_idx;
    logic            w_hs;
    logic            w_full;
    logic            w_enter_drain;

    assign w_hs          = out_valid & out_ready;
    assign w_full        = (r_count == c_line_max);
    assign w_enter_drain = (w_next == DRAIN) && (r_state != DRAIN);

    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_rd_en  = 1'b0;
        w_rd_idx = '0;
        case (r_state)
            GAP:     if (r_gap == c_gap_last) w_next = ST_RD;
            ST_RD:   w_next = ST_CHK;
            ST_CHK:  w_next = uart_dout[ST_RX_RDY] ? DAT_RD : GAP;
            DAT_RD:  w_next = DAT_CHK;
            DAT_CHK: begin
                w_next = GAP;
                case (uart_dout)
                    CH_LF: w_next = GAP;
                    CH_BS: begin
                        if (r_count != '0 && c_echo_on) w_next = EC_RD;
                    end
                    CH_CR: begin
                        if (c_echo_on)             w_next = EC_RD;
                        else if (r_count != '0)    w_next = DRAIN;
                    end
                    default: begin
                        if (!w_full) begin
                            w_we = 1'b1;
                            if (c_echo_on) w_next = EC_RD;
                        end
                    end
                endcase
            end
            EC_RD:   w_next = EC_CHK;
            EC_CHK:  w_next = uart_dout[ST_TX_BUSY] ? EC_RD : EC_WR;
            EC_WR:   w_next = r_close ? DRAIN : GAP;
            DRAIN:   if (w_hs && out_last) w_next = GAP;
            default: w_next = GAP;
        endcase

        // prefetch so each byte is on out_data the cycle after it is requested
        if (w_enter_drain) begin
            w_rd_en  = 1'b1;
            w_rd_idx = '0;
        end else if (r_state == DRAIN && w_hs && !out_last) begin
            w_rd_en  = 1'b1;
            w_rd_idx = r_ptr[AW-1:0] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= GAP;
            r_gap     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_echo    <= 8'h00;
            r_close   <= 1'b0;
            r_ptr     <= '0;
            uart_wr   <= 1'b0;
            uart_rd   <= 1'b0;
            uart_adr  <= UART_ADR_DATA;
            uart_din  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            line_len  <= '0;
            line_ovf  <= 1'b0;
        end else begin
            r_state <= w_next;

            // strobes are decoded from the next state so they line up with it
            uart_rd <= (w_next == ST_RD) || (w_next == DAT_RD) || (w_next == EC_RD);
            uart_wr <= (w_next == EC_WR);
            if (w_next == ST_RD || w_next == EC_RD) begin
                uart_adr <= UART_ADR_STAT;
            end else if (w_next == DAT_RD || w_next == EC_WR) begin
                uart_adr <= UART_ADR_DATA;
            end
            if (w_next == EC_WR) begin
                uart_din <= r_echo;
            end

            case (r_state)
                GAP: r_gap <= (r_gap == c_gap_last) ? '0 : r_gap + 1'b1;
                DAT_CHK: begin
                    r_echo  <= uart_dout;
                    r_close <= 1'b0;
                    case (uart_dout)
                        CH_LF: ;
                        CH_BS: if (r_count != '0) r_count <= r_count - 1'b1;
                        CH_CR: r_close <= (r_count != '0);
                        default: begin
                            if (w_full) r_ovf   <= 1'b1;
                            else        r_count <= r_count + 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase

            if (w_enter_drain) begin
                out_valid <= 1'b1;
                out_last  <= (r_count == CW'(1));
                r_ptr     <= '0;
                line_len  <= r_count;
                line_ovf  <= r_ovf;
            end else if (r_state == DRAIN && w_hs) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    r_count   <= '0;
                    r_ovf     <= 1'b0;
                    line_len  <= '0;
                    line_ovf  <= 1'b0;
                end else begin
                    r_ptr    <= r_ptr + 1'b1;
                    out_last <= ((r_ptr + CW'(2)) == r_count);
                end
            end
        end
    end

    line_buf #(
        .LINE_MAX (LINE_MAX)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_idx  (r_count[AW-1:0]),
        .i_wr_data (uart_dout),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_console_line_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_console_line_rx
// Description : Self-checking bench for console_line_rx: uart model, random
//               consumer back-pressure and a queue-based line-editing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_line_rx;
    import console_pkg::*;

    localparam int LINE_MAX = 32;
    localparam int POLL_GAP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_wr, uart_rd;
    logic [1:0]  uart_adr;
    logic [7:0]  uart_din;
    logic [7:0]  uart_dout = 8'h00;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [5:0]  line_len;
    logic        line_ovf;

    always #5 clk = ~clk;

    console_line_rx #(
        .LINE_MAX (LINE_MAX),
        .POLL_GAP (POLL_GAP),
        .ECHO     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_wr   (uart_wr),
        .uart_rd   (uart_rd),
        .uart_adr  (uart_adr),
        .uart_din  (uart_din),
        .uart_dout (uart_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .line_len  (line_len),
        .line_ovf  (line_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- uart model and stream consumer ----------------
    logic [7:0] rxq[$];
    logic [7:0] echo_q[$];
    logic [7:0] cur_line[$];
    logic [7:0] last_line[$];
    int         got_lines  = 0;
    int         rd_pulses  = 0;
    int         hold_cycles = 0;
    logic [5:0] cur_len, last_len;
    logic       cur_ovf, last_ovf;
    logic       last_busy = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (rst) begin
            cur_line.delete();
            prev_stall = 1'b0;
        end else begin
            chk("strobe_excl", uart_rd & uart_wr, 0);
            chk("rd_in_drain", uart_rd & out_valid, 0);
            if (uart_rd) begin
                rd_pulses++;
                if (uart_adr == UART_ADR_STAT) begin
                    last_busy = ($urandom_range(0, 3) == 0);
                    uart_dout = {6'b0, last_busy, rxq.size() != 0};
                end else begin
                    chk("rd_data_avail", rxq.size() != 0, 1);
                    uart_dout = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
                end
            end
            if (uart_wr) begin
                chk("wr_adr", uart_adr, UART_ADR_DATA);
                chk("wr_while_busy", last_busy, 0);
                echo_q.push_back(uart_din);
            end

            if (hold_cycles > 0) begin
                out_ready = 1'b0;
                hold_cycles--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (cur_line.size() == 0) begin
                    cur_len = line_len;
                    cur_ovf = line_ovf;
                end else begin
                    chk("len_stable", line_len, cur_len);
                    chk("ovf_stable", line_ovf, cur_ovf);
                end
                cur_line.push_back(out_data);
                if (out_last) begin
                    last_line = cur_line;
                    last_len  = cur_len;
                    last_ovf  = cur_ovf;
                    cur_line.delete();
                    got_lines++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] stim[$];
    logic [7:0] exp_echo[$];
    logic [7:0] exp_line[$];
    logic [7:0] m_buf[$];
    logic       m_ovf = 1'b0;
    logic       exp_ovf;
    bit         exp_has_line;
    int         prev_lines;

    task automatic model_run();
        logic [7:0] c;
        exp_echo.delete();
        exp_line.delete();
        exp_has_line = 0;
        foreach (stim[i]) begin
            c = stim[i];
            if (c == 8'h0a) begin
            end else if (c == 8'h08) begin
                if (m_buf.size() > 0) begin
                    void'(m_buf.pop_back());
                    exp_echo.push_back(c);
                end
            end else if (c == 8'h0d) begin
                exp_echo.push_back(c);
                if (m_buf.size() > 0) begin
                    exp_line     = m_buf;
                    exp_ovf      = m_ovf;
                    exp_has_line = 1;
                    m_buf.delete();
                    m_ovf = 1'b0;
                end
            end else if (m_buf.size() < LINE_MAX) begin
                m_buf.push_back(c);
                exp_echo.push_back(c);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic set_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic start_stim();
        model_run();
        echo_q.delete();
        prev_lines = got_lines;
        foreach (stim[i]) rxq.push_back(stim[i]);
    endtask

    task automatic finish_stim(input string tag, input int extra_echo);
        int budget = 0;
        while ((echo_q.size() < exp_echo.size() + extra_echo ||
                (exp_has_line && got_lines == prev_lines)) && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        chk($sformatf("%s_timeout", tag), budget < 20000, 1);
        repeat (30) @(posedge clk);
        chk($sformatf("%s_echo_n", tag), echo_q.size(), exp_echo.size() + extra_echo);
        foreach (exp_echo[i])
            if (i < echo_q.size()) chk($sformatf("%s_echo%0d", tag, i), echo_q[i], exp_echo[i]);
        chk($sformatf("%s_lines", tag), got_lines - prev_lines, exp_has_line ? 1 : 0);
        if (exp_has_line && got_lines != prev_lines) begin
            chk($sformatf("%s_nbytes", tag), last_line.size(), exp_line.size());
            foreach (exp_line[i])
                if (i < last_line.size()) chk($sformatf("%s_byte%0d", tag, i), last_line[i], exp_line[i]);
            chk($sformatf("%s_len", tag), last_len, exp_line.size());
            chk($sformatf("%s_ovf", tag), last_ovf, exp_ovf);
        end
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s_wr", tag), uart_wr, 0);
        chk($sformatf("%s_rd", tag), uart_rd, 0);
        chk($sformatf("%s_adr", tag), uart_adr, 0);
        chk($sformatf("%s_din", tag), uart_din, 0);
        chk($sformatf("%s_valid", tag), out_valid, 0);
        chk($sformatf("%s_last", tag), out_last, 0);
        chk($sformatf("%s_data", tag), out_data, 0);
        chk($sformatf("%s_len", tag), line_len, 0);
        chk($sformatf("%s_ovf", tag), line_ovf, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         budget;
        int         rd_mark;
        logic       v0;
        logic [7:0] d0;
        int         len;
        int         r;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset");

        // "w w" CR
        set_stim("w w"); stim.push_back(8'h0d);
        start_stim(); finish_stim("ww", 0);

        // LF is neither stored nor echoed
        set_stim("a"); stim.push_back(8'h0a); stim.push_back(8'h62); stim.push_back(8'h0d);
        start_stim(); finish_stim("lf", 0);

        // backspace editing
        set_stim("ab"); stim.push_back(8'h08); stim.push_back(8'h63); stim.push_back(8'h0d);
        start_stim(); finish_stim("bs", 0);

        // backspace on empty line, then a one-char line
        stim.delete(); stim.push_back(8'h08); stim.push_back(8'h71); stim.push_back(8'h0d);
        start_stim(); finish_stim("bs_empty", 0);

        // lone CR: echoed, nothing streamed
        stim.delete(); stim.push_back(8'h0d);
        start_stim(); finish_stim("cr_only", 0);

        // overflow: 40 chars into a 32-byte line
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(8'h78);
        stim.push_back(8'h0d);
        start_stim(); finish_stim("ovf", 0);

        // back-pressure mid-drain with a character waiting in the uart
        set_stim("abcdef"); stim.push_back(8'h0d);
        start_stim();
        budget = 0;
        while (cur_line.size() < 2 && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        chk("hold_reach", budget < 20000, 1);
        hold_cycles = 20;
        rd_mark = rd_pulses;
        rxq.push_back(8'h7a);
        repeat (3) @(posedge clk);
        #1 v0 = out_valid; d0 = out_data;
        repeat (14) @(posedge clk);
        #1;
        chk("hold_valid_start", v0, 1);
        chk("hold_valid_end", out_valid, 1);
        chk("hold_data", out_data, d0);
        chk("hold_no_rd", rd_pulses - rd_mark, 0);
        finish_stim("hold", 1);
        if (echo_q.size() > exp_echo.size())
            chk("hold_z_echo", echo_q[exp_echo.size()], 8'h7a);
        stim.delete(); stim.push_back(8'h7a);
        model_run();
        stim.delete(); stim.push_back(8'h0d);
        start_stim(); finish_stim("z_line", 0);

        // reset after 5 characters of a line
        set_stim("abcde");
        start_stim(); finish_stim("pre_rst", 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset("midrst");
        m_buf.delete();
        m_ovf = 1'b0;
        set_stim("x"); stim.push_back(8'h0d);
        start_stim(); finish_stim("post_rst", 0);

        // random lines with edits
        for (int k = 0; k < 8; k++) begin
            stim.delete();
            len = $urandom_range(0, 45);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      stim.push_back(8'h08);
                else if (r == 1) stim.push_back(8'h0a);
                else             stim.push_back(8'($urandom_range(33, 126)));
            end
            stim.push_back(8'h0d);
            start_stim(); finish_stim($sformatf("rnd%0d", k), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/console_line_rx.md
# console_line_rx

Target-side console line receiver. It masters the `uart` register port, polls status, reads received characters and echoes them back. It assembles characters into a line buffer until carriage return, then streams the completed line to the consumer (Forth text interpreter front end) over a valid/ready byte stream. It is the receiving end of a host that types command lines such as `: w 30 0 do i . loop ;  w w` followed by 0x0d.

## Interface
- `LINE_MAX`, 32: line buffer depth in bytes (power of two, 4..256).
- `POLL_GAP`, 10: idle cycles between consecutive status polls.
- `ECHO`, 1: 1 = echo accepted characters to the UART transmitter.
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `uart_wr`  out  1  one-cycle write strobe to `uart`.
- `uart_rd`  out  1  one-cycle read strobe to `uart`.
- `uart_adr`  out  2  register address: 2'b00 data, 2'b10 status.
- `uart_din`  out  8  write data to `uart`.
- `uart_dout`  in  8  read data from `uart`, valid the cycle after `uart_rd`. Status bit0 = rx byte available; bit1 = tx busy.
- `out_data`  out  8  line byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts byte when high with `out_valid`.
- `out_last`  out  1  marks the final byte of a line.
- `line_len`  out  $clog2(LINE_MAX)+1  length of the line being drained.
- `line_ovf`  out  1  line being drained lost characters to overflow.

## Operation
- FSM states: GAP, ST_RD, ST_CHK, DAT_RD, DAT_CHK, EC_RD, EC_CHK, EC_WR, DRAIN.
- GAP: count `POLL_GAP` cycles, then go to ST_RD.
- ST_RD: assert `uart_rd`, `uart_adr`=2'b10, then go to ST_CHK.
- ST_CHK: sample `uart_dout`. If bit0=1, go to DAT_RD; else go to GAP.
- DAT_RD: assert `uart_rd`, `uart_adr`=2'b00, then go to DAT_CHK. DAT_CHK classifies the byte:
  - 0x0a: discarded, no echo, go to GAP.
  - 0x08: if count>0, decrement count and echo; else discard.
  - 0x0d: close the line and echo. If count>0, go to DRAIN after the echo completes; if count=0, return to GAP without streaming.
  - Other byte with count<LINE_MAX: store at index count, increment count, echo.
  - Other byte with count=LINE_MAX: drop it, set the sticky overflow flag, no echo.
- Echo path (EC_RD/EC_CHK/EC_WR): poll status until bit1=0, then one cycle of `uart_wr`, `uart_adr`=2'b00, `uart_din`=byte. If `ECHO`=0, skip the echo path.
- DRAIN: present bytes 0..count-1 in order. `out_last` is high with byte count-1. `line_len`=count and `line_ovf`=flag are stable for the whole drain. After the last handshake, clear count and flag and go to GAP.
- While in DRAIN, no `uart_rd` is issued. Incoming characters wait in the UART.

## Timing
- Reset values: `uart_wr`, `uart_rd`, `uart_din`, `out_valid`, `out_last`, `line_ovf` = 0. `uart_adr`=2'b00, `out_data`=0, `line_len`=0. State = GAP with gap counter 0. Count = 0, overflow flag = 0.
- Strobes (`uart_rd`, `uart_wr`) are single-cycle and registered; never both high together. `uart_adr` and `uart_din` are held with the strobe.
- `uart_dout` is sampled exactly one cycle after `uart_rd`.
- Minimum character latency: status read 2 cycles + data read 2 cycles + echo (status 2, write 1) = 7 cycles, excluding GAP.
- CR to first `out_valid`: the echo path completes first, then `out_valid` rises in the cycle after EC_WR.
- Stream rule: `out_data`, `out_last`, `out_valid` are held until `out_ready`. The next byte is presented in the cycle after the handshake (one byte per cycle at full throughput, registered output).
- `rst` asserted mid-line or mid-drain: all state returns to reset values on the next edge. The partial line is discarded; no `out_valid` afterwards until a new line.

## Structure
- Shared package `console_pkg`:
  - address constants `UART_ADR_DATA`=2'b00, `UART_ADR_STAT`=2'b10;
  - status bit indices `ST_RX_RDY`=0, `ST_TX_BUSY`=1;
  - char constants `CH_CR`=8'h0d, `CH_LF`=8'h0a, `CH_BS`=8'h08;
  - FSM state enum.
- Sub-module `line_buf`: `LINE_MAX`×8 register array with a write port (index, data, we) and a registered read port (index).

## Test plan
- Send "w w"+0x0d through a `uart` model: model receives echo 77 20 77 0d; stream outputs 77, 20, 77 with `out_last` on the third byte; `line_len`=3; `line_ovf`=0.
- Send "a",0x0a,"b",0x0d: 0x0a is neither echoed nor stored; stream outputs 61, 62; `line_len`=2.
- Send "ab",0x08,"c",0x0d: echo 61 62 08 63 0d; stream outputs 61, 63; `line_len`=2. A 0x08 with an empty line produces no echo.
- With `LINE_MAX`=32, send 40×0x78 then 0x0d: 32 echoes plus 0d; 32 bytes streamed; `line_ovf`=1; `line_len`=32.
- Hold `out_ready`=0 for 20 cycles mid-drain: `out_data` and `out_valid` are stable. A byte injected into the UART meanwhile sees no `uart_rd` until the drain ends, then is read.
- Assert `rst` for 1 cycle after 5 bytes of a line: all outputs return to reset values. The next "x"+0x0d yields a single byte 78 with `line_len`=1.
